// File: rtl/relay_pkg.sv
// Shared encodings and default timing constants for the relay actuator controller.
package relay_pkg;

    localparam int unsigned TICK_PERIOD_MS = 16;
    localparam int unsigned TIMER_W        = 8;
    localparam int unsigned FAULT_CNT_W    = 2;

    localparam int unsigned DEF_DEBOUNCE_TICKS = 4;
    localparam int unsigned DEF_SETTLE_TICKS   = 12;
    localparam int unsigned DEF_HOLD_TICKS     = 31;
    localparam int unsigned DEF_MAX_FAULTS     = 3;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_SW_ON   = 3'd1,
        ST_ON      = 3'd2,
        ST_SW_OFF  = 3'd3,
        ST_LOCKOUT = 3'd4
    } relay_state_t;

endpackage

// File: rtl/contact_debouncer.sv
// Two-flop synchronizer plus consecutive-sample debouncer for the relay aux contact.
module contact_debouncer
    import relay_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
    input  logic clk_16ms,
    input  logic rst,
    input  logic enable,
    input  logic raw,
    output logic state
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + CNT_W'(1);

    // Synchronizer runs every edge, even while the rest of the block is frozen
    always_ff @(posedge clk_16ms) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk_16ms) begin
        if (rst) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (enable) begin
            if (sync_q2 == state) begin
                cnt <= '0;
            end else if (cnt_nxt == CNT_W'(DEBOUNCE_TICKS)) begin
                cnt   <= '0;
                state <= ~state;
            end else begin
                cnt <= cnt_nxt;
            end
        end
    end

endmodule

// File: rtl/relay_actuator_ctrl.sv
// Relay coil driver: anti-chatter hold, contact settle supervision, retry and lockout.
module relay_actuator_ctrl
    import relay_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int unsigned SETTLE_TICKS   = DEF_SETTLE_TICKS,
    parameter int unsigned HOLD_TICKS     = DEF_HOLD_TICKS,
    parameter int unsigned MAX_FAULTS     = DEF_MAX_FAULTS
) (
    input  logic                   clk_16ms,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   relay_cmd,
    input  logic                   contact_fb,
    input  logic                   clear_fault,
    output logic                   coil_out,
    output logic                   contact_state,
    output logic                   busy,
    output logic                   fault,
    output logic [FAULT_CNT_W-1:0] fault_cnt
);

    relay_state_t           state;
    logic [TIMER_W-1:0]     hold;
    logic [TIMER_W-1:0]     settle;
    logic [TIMER_W-1:0]     settle_nxt;
    logic [FAULT_CNT_W-1:0] fault_cnt_inc;
    logic                   hold_expired;
    logic                   settle_timeout;

    contact_debouncer #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debouncer (
        .clk_16ms(clk_16ms),
        .rst     (rst),
        .enable  (enable),
        .raw     (contact_fb),
        .state   (contact_state)
    );

    // Hold counts down to zero; zero means a new command may be accepted
    assign hold_expired   = (hold == '0);
    assign settle_nxt     = settle + TIMER_W'(1);
    assign settle_timeout = (settle_nxt == TIMER_W'(SETTLE_TICKS));
    assign fault_cnt_inc  = (fault_cnt == FAULT_CNT_W'(MAX_FAULTS)) ? fault_cnt
                                                                    : fault_cnt + FAULT_CNT_W'(1);

    always_ff @(posedge clk_16ms) begin
        if (rst) begin
            state     <= ST_OFF;
            coil_out  <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            fault_cnt <= '0;
            hold      <= '0;
            settle    <= '0;
        end else if (enable) begin
            if (!hold_expired && (state == ST_OFF || state == ST_ON)) begin
                hold <= hold - TIMER_W'(1);
            end

            case (state)
                ST_OFF: begin
                    if (contact_state) begin
                        state    <= ST_LOCKOUT;
                        coil_out <= 1'b0;
                        busy     <= 1'b0;
                        fault    <= 1'b1;
                    end else if (hold_expired && relay_cmd) begin
                        state    <= ST_SW_ON;
                        coil_out <= 1'b1;
                        busy     <= 1'b1;
                        settle   <= '0;
                    end
                end

                ST_SW_ON: begin
                    if (contact_state) begin
                        state  <= ST_ON;
                        busy   <= 1'b0;
                        hold   <= TIMER_W'(HOLD_TICKS);
                        settle <= '0;
                    end else if (settle_timeout) begin
                        settle    <= '0;
                        fault_cnt <= fault_cnt_inc;
                        coil_out  <= 1'b0;
                        busy      <= 1'b0;
                        if (fault_cnt_inc == FAULT_CNT_W'(MAX_FAULTS)) begin
                            state <= ST_LOCKOUT;
                            fault <= 1'b1;
                        end else begin
                            state <= ST_OFF;
                            hold  <= TIMER_W'(HOLD_TICKS);
                        end
                    end else begin
                        settle <= settle_nxt;
                    end
                end

                ST_ON: begin
                    if (!contact_state) begin
                        state    <= ST_LOCKOUT;
                        coil_out <= 1'b0;
                        busy     <= 1'b0;
                        fault    <= 1'b1;
                    end else if (hold_expired && !relay_cmd) begin
                        state    <= ST_SW_OFF;
                        coil_out <= 1'b0;
                        busy     <= 1'b1;
                        settle   <= '0;
                    end
                end

                ST_SW_OFF: begin
                    if (!contact_state) begin
                        state  <= ST_OFF;
                        busy   <= 1'b0;
                        hold   <= TIMER_W'(HOLD_TICKS);
                        settle <= '0;
                    end else if (settle_timeout) begin
                        settle    <= '0;
                        fault_cnt <= fault_cnt_inc;
                        busy      <= 1'b0;
                        if (fault_cnt_inc == FAULT_CNT_W'(MAX_FAULTS)) begin
                            state    <= ST_LOCKOUT;
                            coil_out <= 1'b0;
                            fault    <= 1'b1;
                        end else begin
                            state    <= ST_ON;
                            coil_out <= 1'b1;
                            hold     <= TIMER_W'(HOLD_TICKS);
                        end
                    end else begin
                        settle <= settle_nxt;
                    end
                end

                ST_LOCKOUT: begin
                    coil_out <= 1'b0;
                    busy     <= 1'b0;
                    fault    <= 1'b1;
                    // Clearing leaves hold expired so a pending command is taken at once
                    if (clear_fault) begin
                        state <= ST_OFF;
                        fault <= 1'b0;
                        hold  <= '0;
                    end
                end

                default: begin
                    state    <= ST_OFF;
                    coil_out <= 1'b0;
                    busy     <= 1'b0;
                    fault    <= 1'b0;
                end
            endcase

            if (clear_fault) begin
                fault_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_relay_actuator_ctrl.sv
// Directed bench for relay_actuator_ctrl with hand-computed tick-by-tick expectations.
module tb_relay_actuator_ctrl;

    logic       clk_16ms;
    logic       rst;
    logic       enable;
    logic       relay_cmd;
    logic       contact_fb;
    logic       clear_fault;
    logic       coil_out;
    logic       contact_state;
    logic       busy;
    logic       fault;
    logic [1:0] fault_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    relay_actuator_ctrl dut (
        .clk_16ms     (clk_16ms),
        .rst          (rst),
        .enable       (enable),
        .relay_cmd    (relay_cmd),
        .contact_fb   (contact_fb),
        .clear_fault  (clear_fault),
        .coil_out     (coil_out),
        .contact_state(contact_state),
        .busy         (busy),
        .fault        (fault),
        .fault_cnt    (fault_cnt)
    );

    initial clk_16ms = 1'b0;
    always #5 clk_16ms = ~clk_16ms;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n active edges, then settle just past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk_16ms);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic c, input logic b,
                              input logic f, input logic [1:0] cnt);
        check({tag, ".coil"},  8'(coil_out),  8'(c));
        check({tag, ".busy"},  8'(busy),      8'(b));
        check({tag, ".fault"}, 8'(fault),     8'(f));
        check({tag, ".cnt"},   8'(fault_cnt), 8'(cnt));
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b1;
        relay_cmd   = 1'b0;
        contact_fb  = 1'b0;
        clear_fault = 1'b0;
        step(2);
        rst = 1'b0;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        check("reset.contact", 8'(contact_state), 8'd0);

        // Switch on with contact following two ticks after coil
        relay_cmd = 1'b1;
        step(1);
        check_outs("on.t1", 1'b1, 1'b1, 1'b0, 2'd0);
        step(2);
        contact_fb = 1'b1;
        step(5);
        check("on.t8.contact", 8'(contact_state), 8'd0);
        step(1);
        check("on.t9.contact", 8'(contact_state), 8'd1);
        check("on.t9.busy", 8'(busy), 8'd1);
        step(1);
        check_outs("on.t10", 1'b1, 1'b0, 1'b0, 2'd0);

        // Off request 5 ticks into ON waits out the 31-tick hold
        step(5);
        relay_cmd = 1'b0;
        step(26);
        check_outs("hold.last", 1'b1, 1'b0, 1'b0, 2'd0);
        step(1);
        check_outs("hold.sw_off", 1'b0, 1'b1, 1'b0, 2'd0);
        contact_fb = 1'b0;
        step(6);
        check("off.contact", 8'(contact_state), 8'd0);
        check("off.busy_pending", 8'(busy), 8'd1);
        step(1);
        check_outs("off.done", 1'b0, 1'b0, 1'b0, 2'd0);

        // Contact never closes: three settle timeouts then lockout
        relay_cmd = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(31);
            check("retry.wait.coil", 8'(coil_out), 8'd0);
            step(1);
            check("retry.start.coil", 8'(coil_out), 8'd1);
            step(11);
            check("settle.last.coil", 8'(coil_out), 8'd1);
            check("settle.last.cnt", 8'(fault_cnt), 8'(k - 1));
            step(1);
            check_outs("timeout", 1'b0, 1'b0, (k == 3), 2'(k));
        end

        // Lockout ignores relay_cmd until cleared, then switches on next tick
        step(3);
        check_outs("lockout.hold", 1'b0, 1'b0, 1'b1, 2'd3);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        check_outs("clear", 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);
        check_outs("clear.sw_on", 1'b1, 1'b1, 1'b0, 2'd0);

        // Confirm ON, then glitch the contact open for 1..3 ticks
        contact_fb = 1'b1;
        step(7);
        check_outs("on2", 1'b1, 1'b0, 1'b0, 2'd0);
        for (int len = 1; len <= 3; len++) begin
            contact_fb = 1'b0;
            step(len);
            contact_fb = 1'b1;
            step(8);
            check("glitch.contact", 8'(contact_state), 8'd1);
            check("glitch.fault", 8'(fault), 8'd0);
        end
        contact_fb = 1'b0;
        step(6);
        check("dropout.contact", 8'(contact_state), 8'd0);
        check("dropout.pre_fault", 8'(fault), 8'd0);
        step(1);
        check_outs("dropout.lockout", 1'b0, 1'b0, 1'b1, 2'd0);

        // Freeze mid SW_ON: settle timer must not advance while disabled
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        step(1);
        check_outs("frz.sw_on", 1'b1, 1'b1, 1'b0, 2'd0);
        step(4);
        enable = 1'b0;
        step(20);
        check_outs("frz.held", 1'b1, 1'b1, 1'b0, 2'd0);
        check("frz.contact", 8'(contact_state), 8'd0);
        enable = 1'b1;
        step(7);
        check_outs("frz.resume", 1'b1, 1'b1, 1'b0, 2'd0);
        step(1);
        check_outs("frz.timeout", 1'b0, 1'b0, 1'b0, 2'd1);

        // Reset mid SW_ON aborts with no fault and re-arms immediate acceptance
        step(31);
        step(1);
        check_outs("rst.sw_on", 1'b1, 1'b1, 1'b0, 2'd1);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_outs("rst.mid", 1'b0, 1'b0, 1'b0, 2'd0);
        step(1);
        check_outs("rst.restart", 1'b1, 1'b1, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
